mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the cycles each MMU access is held (legal range 1..15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch request, held until if_ready.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_rdata  output  32  fetched word, valid while if_ready=1.
REQ-007 if_ready  output  1  one-cycle fetch-complete pulse.
REQ-008 mem_read  input  1  data read request, held until mem_ready.
REQ-009 mem_write  input  1  data write request, held until mem_ready.
REQ-010 mem_addr  input  32  data byte address.
REQ-011 mem_wdata  input  32  write data.
REQ-012 mem_bytemode  input  1  byte access (1) or word access (0).
REQ-013 mem_rdata  output  32  read result, valid while mem_ready=1.
REQ-014 mem_ready  output  1  one-cycle data-complete pulse.
REQ-015 mmu_read, mmu_write  output  1 each  drive the MMU if_read/if_write.
REQ-016 mmu_addr  output  32; mmu_wdata  output  32; mmu_bytemode  output  1  MMU address, input_data, bytemode.
REQ-017 mmu_rdata  input  32  MMU output_data.
REQ-018 stall_req  output  1  pipeline stall request.

Function
REQ-019 FSM states: IDLE, ACCESS, DONE; encoding is 2 bits.
REQ-020 In IDLE with any request, next edge SHALL enter ACCESS, register the mmu_* outputs from the granted port, and load wait counter = WAIT_CYCLES-1.
REQ-021 Grant priority: data port (mem_read|mem_write) over fetch; an ungranted fetch stays pending and is served after DONE.
REQ-022 mem_read and mem_write both high SHALL be treated as a write; mmu_read=0.
REQ-023 Fetch grant: mmu_read=1, mmu_write=0, mmu_bytemode=0, mmu_addr=if_addr, mmu_wdata=0.
REQ-024 mmu_* outputs SHALL stay constant throughout ACCESS; requester changes to inputs are ignored until IDLE.
REQ-025 In ACCESS, counter decrements each edge; at the edge where counter=0, capture mmu_rdata into the granted port's rdata register (reads only), clear mmu_read/mmu_write, enter DONE.
REQ-026 In DONE, the granted port's ready SHALL be 1 for exactly one cycle; next edge returns to IDLE; no new grant in DONE.
REQ-027 Latency: request seen in IDLE cycle n -> mmu strobes in cycles n+1..n+WAIT_CYCLES -> ready in cycle n+WAIT_CYCLES+1.
REQ-028 if_rdata/mem_rdata SHALL hold their last captured value until the next read on that port; write completion leaves mem_rdata unchanged.
REQ-029 A request dropped mid-ACCESS SHALL NOT abort the access; ready still pulses in DONE.
REQ-030 stall_req (combinational) = (if_req & ~if_ready) | ((mem_read|mem_write) & ~mem_ready).
REQ-031 Addresses (including UART space, addr[29]=1) SHALL pass unmodified; the block performs no decoding.

Reset
REQ-032 On rst: state=IDLE, counter=0, mmu_read=mmu_write=0, mmu_addr=mmu_wdata=0, mmu_bytemode=0, if_ready=mem_ready=0, if_rdata=mem_rdata=0.
REQ-033 rst asserted mid-ACCESS SHALL drop mmu_read/mmu_write at that same edge, with no ready pulse.
REQ-034 The first grant after rst deasserts SHALL occur no earlier than the first edge after deassertion.

Structure
REQ-035 The FSM state type and the default WAIT_CYCLES constant SHALL live in the shared cpu_defs package.
REQ-036 Single flat module; no sub-module.

Verification
REQ-037 Fetch: if_req=1, if_addr=0x80000000, mmu_rdata=0x3C011234, WAIT=2 -> mmu_read in cycles 1-2, if_ready cycle 3, if_rdata=0x3C011234.
REQ-038 Conflict: if_req and mem_read (addr 0x80400004) both in cycle 0 -> data served first (mem_ready cycle 3), fetch grant cycle 4, if_ready cycle 7.
REQ-039 Byte write: mem_write=1, mem_bytemode=1, addr 0x80400003, wdata 0xAB -> mmu_write=1, mmu_bytemode=1, mmu_wdata=0xAB for 2 cycles; mem_rdata unchanged.
REQ-040 Read+write both high -> mmu_write=1, mmu_read=0, mem_ready one pulse.
REQ-041 rst=1 in the 2nd ACCESS cycle -> mmu_read=0 next cycle, no ready pulse, state IDLE.
REQ-042 stall_req check: high from request cycle through cycle before ready; low in ready cycle with no other pending request.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: memory arbiter FSM state, grant owner, default access length.
package cpu_defs;

  // Default number of cycles an MMU access is held
  localparam int unsigned WAIT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  // Which requester owns the current access
  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } arb_grant_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data ports share one MMU.
// Data port wins on conflict; a losing fetch stays pending and is served after DONE.
// Each access holds the MMU strobes for WAIT_CYCLES cycles, then pulses ready for one cycle.
module mem_arbiter
  import cpu_defs::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  // data port
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_bytemode,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  // MMU side
  output logic        mmu_read,
  output logic        mmu_write,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_wdata,
  output logic        mmu_bytemode,
  input  logic [31:0] mmu_rdata,
  // pipeline
  output logic        stall_req
);

  // Counter is loaded with WAIT_CYCLES-1 so the strobes cover exactly WAIT_CYCLES cycles
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  arb_state_e  state_q, state_d;
  arb_grant_e  grant_q, grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mmu_read_q, mmu_read_d;
  logic        mmu_write_q, mmu_write_d;
  logic [31:0] mmu_addr_q, mmu_addr_d;
  logic [31:0] mmu_wdata_q, mmu_wdata_d;
  logic        mmu_bytemode_q, mmu_bytemode_d;
  logic        if_ready_q, if_ready_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic data_req;
  assign data_req = mem_read | mem_write;

  // Next-state: grant in IDLE, count down in ACCESS, single ready cycle in DONE
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    cnt_d          = cnt_q;
    mmu_read_d     = mmu_read_q;
    mmu_write_d    = mmu_write_q;
    mmu_addr_d     = mmu_addr_q;
    mmu_wdata_d    = mmu_wdata_q;
    mmu_bytemode_d = mmu_bytemode_q;
    if_rdata_d     = if_rdata_q;
    mem_rdata_d    = mem_rdata_q;
    if_ready_d     = 1'b0;
    mem_ready_d    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (data_req) begin
          // read+write together is treated as a write
          state_d        = ARB_ACCESS;
          grant_d        = GNT_DATA;
          cnt_d          = CNT_INIT;
          mmu_read_d     = mem_read & ~mem_write;
          mmu_write_d    = mem_write;
          mmu_addr_d     = mem_addr;
          mmu_wdata_d    = mem_wdata;
          mmu_bytemode_d = mem_bytemode;
        end else if (if_req) begin
          state_d        = ARB_ACCESS;
          grant_d        = GNT_FETCH;
          cnt_d          = CNT_INIT;
          mmu_read_d     = 1'b1;
          mmu_write_d    = 1'b0;
          mmu_addr_d     = if_addr;
          mmu_wdata_d    = 32'h0;
          mmu_bytemode_d = 1'b0;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (mmu_read_q) begin
            if (grant_q == GNT_DATA) mem_rdata_d = mmu_rdata;
            else                     if_rdata_d  = mmu_rdata;
          end
          mmu_read_d  = 1'b0;
          mmu_write_d = 1'b0;
          if_ready_d  = (grant_q == GNT_FETCH);
          mem_ready_d = (grant_q == GNT_DATA);
          state_d     = ARB_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB_IDLE;
      grant_q        <= GNT_FETCH;
      cnt_q          <= 4'd0;
      mmu_read_q     <= 1'b0;
      mmu_write_q    <= 1'b0;
      mmu_addr_q     <= 32'h0;
      mmu_wdata_q    <= 32'h0;
      mmu_bytemode_q <= 1'b0;
      if_ready_q     <= 1'b0;
      mem_ready_q    <= 1'b0;
      if_rdata_q     <= 32'h0;
      mem_rdata_q    <= 32'h0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      cnt_q          <= cnt_d;
      mmu_read_q     <= mmu_read_d;
      mmu_write_q    <= mmu_write_d;
      mmu_addr_q     <= mmu_addr_d;
      mmu_wdata_q    <= mmu_wdata_d;
      mmu_bytemode_q <= mmu_bytemode_d;
      if_ready_q     <= if_ready_d;
      mem_ready_q    <= mem_ready_d;
      if_rdata_q     <= if_rdata_d;
      mem_rdata_q    <= mem_rdata_d;
    end
  end

  assign mmu_read     = mmu_read_q;
  assign mmu_write    = mmu_write_q;
  assign mmu_addr     = mmu_addr_q;
  assign mmu_wdata    = mmu_wdata_q;
  assign mmu_bytemode = mmu_bytemode_q;
  assign if_ready     = if_ready_q;
  assign mem_ready    = mem_ready_q;
  assign if_rdata     = if_rdata_q;
  assign mem_rdata    = mem_rdata_q;

  // Stall while any request is outstanding and not completing this cycle
  assign stall_req = (if_req & ~if_ready_q) | (data_req & ~mem_ready_q);

endmodule
